fetch_stage: RTL and testbench

Instruction-fetch stage of the 32-bit CPU. Owns the program counter, drives the address into the combinational instruction memory, and registers the returned word into the IF/ID pipeline register for decode. Resolves unconditional jumps locally with zero bubbles. Accepts stall from hazard logic and redirects (taken branches) from the execute stage.

---
 rtl/fetch_stage.sv | 72 +++++++
 tb/tb_fetch_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 32-bit CPU.
// Owns the PC, addresses the combinational instruction memory and registers
// the returned word into the IF/ID pipeline register. Unconditional jumps are
// resolved here with no bubble; redirects from execute flush one slot.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   stall               hold PC, IF/ID and fetch_count this cycle
//   redirect_valid/pc   taken-branch redirect (wins over stall)
//   imem_pc             instruction-memory address (the PC register itself)
//   imem_instr          instruction returned combinationally for imem_pc
//   ifid_instr/pc/pc_plus1/valid  registered IF/ID contents
//   fetch_count         count of valid instructions written into IF/ID
module fetch_stage #(
    parameter int unsigned         PC_WIDTH    = 16,
    parameter int unsigned         INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [5:0]          JUMP_OPCODE = 6'b000001
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [PC_WIDTH-1:0]    imem_pc,
    input  logic [INSTR_WIDTH-1:0] imem_instr,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic [PC_WIDTH-1:0]    ifid_pc,
    output logic [PC_WIDTH-1:0]    ifid_pc_plus1,
    output logic                   ifid_valid,
    output logic [31:0]            fetch_count
);

    localparam int unsigned CNT_WIDTH = 32;

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus1_c;
    logic [PC_WIDTH-1:0] jump_target_c;
    logic                is_jump_c;

    // Sequential successor wraps naturally at PC_WIDTH bits.
    assign pc_plus1_c    = pc + PC_WIDTH'(1);
    // Predecode: jump opcode in the top six bits, absolute target in the low half.
    assign is_jump_c     = (imem_instr[31:26] == JUMP_OPCODE);
    assign jump_target_c = PC_WIDTH'(imem_instr[15:0]);
    assign imem_pc       = pc;

    // PC and IF/ID update; priority rst > redirect > stall > jump > sequential.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            ifid_instr    <= '0;
            ifid_pc       <= '0;
            ifid_pc_plus1 <= '0;
            ifid_valid    <= 1'b0;
            fetch_count   <= '0;
        end else if (redirect_valid) begin
            // Wrong-path word is replaced by a NOOP bubble; count untouched.
            pc         <= redirect_pc;
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            pc            <= is_jump_c ? jump_target_c : pc_plus1_c;
            ifid_instr    <= imem_instr;
            ifid_pc       <= pc;
            ifid_pc_plus1 <= pc_plus1_c;
            ifid_valid    <= 1'b1;
            fetch_count   <= fetch_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized reset/stall/redirect traffic against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] imem_pc;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_plus1;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:65535];

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [15:0] m_pc;
    logic [31:0] m_instr;
    logic [15:0] m_ipc;
    logic [15:0] m_ipc1;
    logic        m_valid;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_pc];

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_pc       (imem_pc),
        .imem_instr    (imem_instr),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus1 (ifid_pc_plus1),
        .ifid_valid    (ifid_valid),
        .fetch_count   (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the fetch rules, compare.
    task automatic cycle(input logic r, input logic s, input logic rv, input logic [15:0] rpc);
        logic [31:0] w;
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        if (r) begin
            m_pc = 16'h0000; m_instr = '0; m_ipc = '0; m_ipc1 = '0; m_valid = 1'b0; m_cnt = '0;
        end else if (rv) begin
            m_pc = rpc; m_instr = '0; m_valid = 1'b0;
        end else if (!s) begin
            w       = mem[m_pc];
            m_instr = w;
            m_ipc   = m_pc;
            m_ipc1  = m_pc + 16'd1;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
            m_pc    = (w[31:26] == 6'b000001) ? w[15:0] : m_pc + 16'd1;
        end
        #1;
        check("imem_pc",       32'(imem_pc),       32'(m_pc));
        check("ifid_instr",    ifid_instr,         m_instr);
        check("ifid_pc",       32'(ifid_pc),       32'(m_ipc));
        check("ifid_pc_plus1", 32'(ifid_pc_plus1), 32'(m_ipc1));
        check("ifid_valid",    32'(ifid_valid),    32'(m_valid));
        check("fetch_count",   fetch_count,        m_cnt);
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        m_pc = '0; m_instr = '0; m_ipc = '0; m_ipc1 = '0; m_valid = 1'b0; m_cnt = '0;

        // Non-jump random program, one jump at 26 targeting 0.
        for (int i = 0; i < 65536; i++) begin
            w = $urandom;
            if (w[31:26] == 6'b000001) w[31:26] = 6'b000010;
            mem[i] = w;
        end
        mem[26] = 32'h0400_0000;

        @(negedge clk);

        // Reset then run
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("rst_valid", 32'(ifid_valid), 32'd0);
        check("rst_pc",    32'(imem_pc),    32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0);
            check("run_ifid_pc", 32'(ifid_pc),   32'(i));
            check("run_count",   fetch_count,    32'(i + 1));
            check("run_valid",   32'(ifid_valid), 32'd1);
        end

        // Stall at pc=5
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0);
            check("stall_imem_pc", 32'(imem_pc), 32'd5);
            check("stall_ifid_pc", 32'(ifid_pc), 32'd4);
            check("stall_count",   fetch_count,  32'd5);
        end
        cycle(0, 0, 0, 0);
        check("unstall_pc0", 32'(ifid_pc), 32'd5);
        cycle(0, 0, 0, 0);
        check("unstall_pc1", 32'(ifid_pc), 32'd6);

        // Redirect at pc=16 to 17
        while (imem_pc != 16'd16 && checks < 2000) cycle(0, 0, 0, 0);
        check("at_pc16", 32'(imem_pc), 32'd16);
        cycle(0, 0, 1, 16'd17);
        check("redir_valid", 32'(ifid_valid), 32'd0);
        check("redir_pc",    32'(imem_pc),    32'd17);
        check("redir_count", fetch_count,     32'd16);
        cycle(0, 0, 0, 0);
        check("redir_tgt",   32'(ifid_pc),    32'd17);
        check("redir_cnt1",  fetch_count,     32'd17);

        // Jump at 26 -> 0, no bubble
        while (imem_pc != 16'd26 && checks < 4000) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("jmp_imem_pc", 32'(imem_pc),    32'd0);
        check("jmp_ifid_pc", 32'(ifid_pc),    32'd26);
        check("jmp_valid",   32'(ifid_valid), 32'd1);
        cycle(0, 0, 0, 0);
        check("jmp_tgt",     32'(ifid_pc),    32'd0);
        check("jmp_tgt_v",   32'(ifid_valid), 32'd1);

        // Redirect+stall to FFFF, then wrap
        cycle(0, 1, 1, 16'hFFFF);
        check("rs_imem_pc", 32'(imem_pc),    32'h0000_FFFF);
        check("rs_valid",   32'(ifid_valid), 32'd0);
        cycle(0, 0, 0, 0);
        check("wrap_ifid_pc", 32'(ifid_pc),       32'h0000_FFFF);
        check("wrap_plus1",   32'(ifid_pc_plus1), 32'd0);
        check("wrap_imem_pc", 32'(imem_pc),       32'd0);

        // Reset wins over stall and redirect
        cycle(1, 1, 1, 16'h1234);
        check("rstmid_pc",    32'(imem_pc), 32'd0);
        check("rstmid_instr", ifid_instr,   32'd0);
        check("rstmid_count", fetch_count,  32'd0);

        // Randomized traffic with jumps sprinkled through memory
        for (int i = 0; i < 65536; i++) begin
            if ($urandom_range(0, 9) == 0) mem[i] = {6'b000001, 10'($urandom), 16'($urandom)};
        end
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 63) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0,
                  16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
